// File: rtl/led_fader.sv
// led_fader: per-LED PWM brightness stage for the rotating-LED pattern.
// A channel whose input is high is driven at full brightness; once the
// input drops, its level ramps down linearly by DECAY_STEP on every decay
// tick until it reaches zero, giving a comet-tail trail behind the pattern.
//
// Datapath: stage 0 holds the per-channel levels, the PWM counter and the
// decay prescaler. Stage 1 registers the compare result onto the pins, so
// no input reaches an output combinationally.
module led_fader #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 12000,
  parameter int DECAY_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] led_in,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5
);

  localparam int NCH   = 5;
  // A divider of 1 still needs a 1-bit prescaler register that sits at 0.
  localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  // Stage 0 state.
  logic [PWM_BITS-1:0]          pwm_cnt_p0;
  logic [PRE_W-1:0]             prescaler_p0;
  logic                         decay_tick_p0;
  logic [NCH-1:0][PWM_BITS-1:0] level_p0;

  // Stage 1 state: registered pin drive.
  logic [NCH-1:0]               led_p1;

  // Saturating decrement: a level at or below the step lands on zero
  // rather than wrapping around to a bright value.
  function automatic logic [PWM_BITS-1:0] sat_decay(
    input logic [PWM_BITS-1:0] lvl
  );
    return (lvl > STEP) ? (lvl - STEP) : '0;
  endfunction

  // PWM compare: full level is forced solid on, because pwm_cnt never
  // exceeds LVL_MAX and the plain compare would leave one dark cycle.
  function automatic logic pwm_out(
    input logic [PWM_BITS-1:0] lvl,
    input logic [PWM_BITS-1:0] cnt
  );
    return (lvl == LVL_MAX) | (cnt < lvl);
  endfunction

  // ---- stage 0: timebase ----

  // Free-running PWM frame counter; wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_p0 <= '0;
    end else begin
      pwm_cnt_p0 <= pwm_cnt_p0 + PWM_BITS'(1);
    end
  end

  // Decay prescaler: one registered tick each time the count returns to 0,
  // so the first tick after reset lands DECAY_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_p0  <= '0;
      decay_tick_p0 <= 1'b0;
    end else if (prescaler_p0 == PRE_LAST) begin
      prescaler_p0  <= '0;
      decay_tick_p0 <= 1'b1;
    end else begin
      prescaler_p0  <= prescaler_p0 + PRE_W'(1);
      decay_tick_p0 <= 1'b0;
    end
  end

  // ---- stage 0: per-channel brightness ----

  // Load to full on a high input (this beats a coincident decay tick),
  // otherwise step down on each tick, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_p0 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (led_in[i]) begin
          level_p0[i] <= LVL_MAX;
        end else if (decay_tick_p0) begin
          level_p0[i] <= sat_decay(level_p0[i]);
        end
      end
    end
  end

  // ---- stage 1: output compare ----

  // Registered PWM drive for every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_p1 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        led_p1[i] <= pwm_out(level_p0[i], pwm_cnt_p0);
      end
    end
  end

  assign D1 = led_p1[0];
  assign D2 = led_p1[1];
  assign D3 = led_p1[2];
  assign D4 = led_p1[3];
  assign D5 = led_p1[4];

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader. Three instances share one clock:
//   dut_a  PWM_BITS=8, DECAY_DIV=4,    DECAY_STEP=4    (reset, fade, collision, rotation)
//   dut_b  PWM_BITS=8, DECAY_DIV=2000, DECAY_STEP=191  (one tick takes 255 to 64, then holds)
//   dut_c  PWM_BITS=8, DECAY_DIV=4,    DECAY_STEP=100  (saturation at zero)
// Expected values are hand-derived edge numbers relative to each reset release.
module tb_led_fader;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [4:0] led_a, led_b, led_c;
  wire  [4:0] d_a, d_b, d_c;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  led_fader #(.PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(4)) dut_a (
    .clk(clk), .rst(rst_a), .led_in(led_a),
    .D1(d_a[0]), .D2(d_a[1]), .D3(d_a[2]), .D4(d_a[3]), .D5(d_a[4])
  );

  led_fader #(.PWM_BITS(8), .DECAY_DIV(2000), .DECAY_STEP(191)) dut_b (
    .clk(clk), .rst(rst_b), .led_in(led_b),
    .D1(d_b[0]), .D2(d_b[1]), .D3(d_b[2]), .D4(d_b[3]), .D5(d_b[4])
  );

  led_fader #(.PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(100)) dut_c (
    .clk(clk), .rst(rst_c), .led_in(led_c),
    .D1(d_c[0]), .D2(d_c[1]), .D3(d_c[2]), .D4(d_c[3]), .D5(d_c[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lva(input int i);
    return 32'(dut_a.level_p0[i]);
  endfunction

  function automatic logic [31:0] lvb(input int i);
    return 32'(dut_b.level_p0[i]);
  endfunction

  function automatic logic [31:0] lvc(input int i);
    return 32'(dut_c.level_p0[i]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic step1();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Advance to edge number base+k.
  task automatic at(input int base, input int k);
    while (edges < base + k) step1();
  endtask

  initial begin
    int ra, rb, rc;
    int act, p1, p2, p3, n255, d5_low, hi, misalign, other;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    led_a = 5'b11111; led_b = 5'b00000; led_c = 5'b00000;

    // ---------------- reset with all inputs high ----------------
    for (int i = 0; i < 3; i++) begin
      step1();
      check("rst_outputs", 32'(d_a), 0);
      for (int c = 0; c < 5; c++) check("rst_level", lva(c), 0);
    end
    rst_a = 1'b0;
    step1();                                  // first sampled led_in
    check("release_out_early", 32'(d_a), 0);
    for (int c = 0; c < 5; c++) check("release_level", lva(c), 255);
    step1();
    check("release_out", 32'(d_a), 32'h1F);

    // ---------------- load and fade on channel 0 ----------------
    rst_a = 1'b1; led_a = 5'b00000;
    step1();
    check("rst2_outputs", 32'(d_a), 0);
    ra = edges;
    rst_a = 1'b0; led_a = 5'b00001;
    at(ra, 1);
    check("load_level", lva(0), 255);
    for (int k = 2; k <= 11; k++) begin
      at(ra, k);
      check("load_d1_solid", 32'(d_a[0]), 1);
      check("load_others_off", 32'(d_a[4:1]), 0);
      if (k == 10) led_a = 5'b00000;
    end
    at(ra, 12);
    check("fade_hold_until_tick", lva(0), 255);
    // Decay edges are ra+13, ra+17, ... ; the 64th lands on 0.
    for (int n = 1; n <= 64; n++) begin
      at(ra, 9 + 4 * n);
      check("fade_step", lva(0), (n < 64) ? 255 - 4 * n : 0);
      if (n % 16 == 0) check("fade_others_off", 32'(d_a[4:1]), 0);
      if (n < 64) begin
        at(ra, 12 + 4 * n);
        check("fade_hold", lva(0), 255 - 4 * n);
      end
    end
    at(ra, 269);
    check("fade_stays_zero", lva(0), 0);
    at(ra, 271);
    check("fade_out_dark", 32'(d_a), 0);

    // ---------------- load/decay collision on channel 2 ----------------
    led_a = 5'b00100;                         // sampled at ra+272, ra+273
    at(ra, 272);
    check("tick_phase", 32'(dut_a.decay_tick_p0), 1);
    check("collide_pre", lva(2), 255);
    at(ra, 273);
    check("collide_load_wins", lva(2), 255);
    led_a = 5'b00000;
    at(ra, 276);
    check("collide_hold", lva(2), 255);
    at(ra, 277);
    check("collide_next_decay", lva(2), 251);
    led_a = 5'b00100;
    at(ra, 278);
    check("reassert_reload", lva(2), 255);
    led_a = 5'b00000;

    // ---------------- rotating input ----------------
    d5_low = 0;
    for (int w = 0; w < 12; w++) begin
      act = w % 4;
      led_a = {1'b1, 4'(4'b0001 << act)};
      for (int k = 0; k < 20; k++) begin
        step1();
        if (d_a[4] !== 1'b1 && !(w == 0 && k == 0)) d5_low++;
      end
      check("rot_active_level", lva(act), 255);
      check("rot_active_solid", 32'(d_a[act]), 1);
      n255 = 0;
      for (int c = 0; c < 4; c++) if (lva(c) == 255) n255++;
      check("rot_one_full", 32'(n255), 1);
      if (w >= 4) begin
        p1 = (act + 3) % 4;
        p2 = (act + 2) % 4;
        p3 = (act + 1) % 4;
        check("rot_trail_order",
              32'((lva(p1) > lva(p2)) && (lva(p2) > lva(p3)) && (lva(p3) > 0)), 1);
      end
    end
    check("rot_d5_solid", 32'(d5_low), 0);
    rst_a = 1'b1; led_a = 5'b00000;
    step1();
    check("midfade_rst_out", 32'(d_a), 0);
    for (int c = 0; c < 5; c++) check("midfade_rst_level", lva(c), 0);
    rst_a = 1'b0;

    // ---------------- duty check at level 64 ----------------
    step1();                                  // rst_b sampled high here
    rb = edges;
    rst_b = 1'b0; led_b = 5'b00001;
    at(rb, 1);
    check("duty_load", lvb(0), 255);
    at(rb, 5);
    led_b = 5'b00000;
    at(rb, 2000);
    check("duty_pre_tick", lvb(0), 255);
    at(rb, 2001);
    check("duty_level", lvb(0), 64);
    hi = 0; misalign = 0; other = 0;
    for (int e = 2002; e <= 2257; e++) begin
      at(rb, e);
      if (d_b[0] === 1'b1) hi++;
      if (d_b[0] !== (((e - 1) % 256) < 64)) misalign++;
      if (d_b[4:1] !== 4'b0000) other++;
    end
    check("duty_high_count", 32'(hi), 64);
    check("duty_alignment", 32'(misalign), 0);
    check("duty_others_off", 32'(other), 0);
    check("duty_level_held", lvb(0), 64);

    // ---------------- saturation with step 100 ----------------
    step1();                                  // rst_c sampled high here
    rc = edges;
    rst_c = 1'b0; led_c = 5'b00001;
    at(rc, 2);
    led_c = 5'b00000;
    at(rc, 4);
    check("sat_loaded", lvc(0), 255);
    at(rc, 5);
    check("sat_first", lvc(0), 155);
    at(rc, 8);
    check("sat_hold", lvc(0), 155);
    at(rc, 9);
    check("sat_second", lvc(0), 55);
    at(rc, 13);
    check("sat_floor", lvc(0), 0);
    at(rc, 17);
    check("sat_no_wrap", lvc(0), 0);
    at(rc, 21);
    check("sat_no_wrap2", lvc(0), 0);
    check("sat_out_dark", 32'(d_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
